dot_sched: RTL

DOT_SCHED -- requirements
Module: dot_sched

---
 rtl/dot_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dot_sched.sv
// dot_sched: round-robin scheduler that streams a V-element job from one of R
// requesters into a shared engine as V/P chunks, then waits for the engine's done.
module dot_sched #(
  parameter  int V   = 4,
  parameter  int P   = 2,
  parameter  int BIT = 32,
  parameter  int R   = 2,
  localparam int RW  = (R > 1) ? $clog2(R) : 1,
  localparam int IW  = $clog2(V) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [R-1:0]  req,
  input  logic          eng_ready,
  input  logic          eng_done,
  output logic [R-1:0]  gnt,
  output logic [RW-1:0] sel,
  output logic          chunk_valid,
  output logic [IW-1:0] chunk_base,
  output logic          chunk_last,
  output logic [R-1:0]  job_done,
  output logic          busy
);

  // state   | meaning
  // S_IDLE  | no job; arbitrate among req from ptr
  // S_ISSUE | offering chunks of the owner's job to the engine
  // S_WAIT  | all chunks accepted; waiting for eng_done
  // S_DONE  | one-cycle job_done pulse to the owner

  if (P < 1 || P > V || (V % P) != 0 || BIT < 1) begin : g_bad_cfg
    $fatal(1, "dot_sched: illegal configuration, need 1 <= P <= V and V mod P == 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [IW-1:0] LAST_BASE = IW'(V - P);
  localparam logic [IW-1:0] STEP      = IW'(P);

  state_t        state_q, state_d;
  logic [RW-1:0] owner_q, owner_d;
  logic [RW-1:0] ptr_q, ptr_d;
  logic          chunk_valid_q, chunk_valid_d;
  logic [IW-1:0] chunk_base_q, chunk_base_d;

  logic          win_found;
  logic [RW-1:0] win_idx;
  logic [RW:0]   cand;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      chunk_valid_q <= 1'b0;
      chunk_base_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      chunk_valid_q <= chunk_valid_d;
      chunk_base_q  <= chunk_base_d;
    end
  end

  // First requesting index at or after ptr, wrapping modulo R.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < R; i++) begin
      cand = {1'b0, ptr_q} + (RW+1)'(i);
      if (cand >= (RW+1)'(R)) cand = cand - (RW+1)'(R);
      if (!win_found && req[cand[RW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[RW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    chunk_valid_d = chunk_valid_q;
    chunk_base_d  = chunk_base_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d       = S_ISSUE;
          owner_d       = win_idx;
          chunk_valid_d = 1'b1;
          chunk_base_d  = '0;
        end
      end
      S_ISSUE: begin
        if (chunk_valid_q && eng_ready) begin
          if (chunk_base_q == LAST_BASE) begin
            chunk_valid_d = 1'b0;
            chunk_base_d  = '0;
            state_d       = S_WAIT;
          end else begin
            chunk_base_d  = chunk_base_q + STEP;
          end
        end
      end
      S_WAIT: begin
        if (eng_done) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = (owner_q == RW'(R - 1)) ? '0 : owner_q + RW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    sel         = busy ? owner_q : '0;
    chunk_valid = chunk_valid_q;
    chunk_base  = chunk_base_q;
    chunk_last  = chunk_valid_q && (chunk_base_q == LAST_BASE);
    gnt         = '0;
    job_done    = '0;
    for (int i = 0; i < R; i++) begin
      gnt[i]      = busy && (owner_q == RW'(i));
      job_done[i] = (state_q == S_DONE) && (owner_q == RW'(i));
    end
  end

endmodule
